// File: rtl/stm32_bus_pkg.sv
// Command codes, payload lengths and FSM state encoding for the DATA_BUS/DATA_SYNC protocol.
// Shared by the bus master, its write buffer and benches that model the responder.
package stm32_bus_pkg;

    localparam logic [7:0] BUS_TEST    = 8'h00;
    localparam logic [7:0] GET_PARAMS  = 8'h01;
    localparam logic [7:0] SEND_PARAMS = 8'h02;
    localparam logic [7:0] TX_IQ       = 8'h03;
    localparam logic [7:0] RX_IQ       = 8'h04;
    localparam logic [7:0] RESET_ON    = 8'h05;
    localparam logic [7:0] RESET_OFF   = 8'h06;
    localparam logic [7:0] FLASH_READ  = 8'h07;
    localparam logic [7:0] GET_INFO    = 8'h08;

    localparam int GET_PARAMS_LEN   = 21;
    localparam int SEND_PARAMS_LEN  = 11;
    localparam int TX_IQ_LEN        = 6;
    localparam int RX_IQ_FRAME_LEN  = 6;
    localparam int RX_IQ_FRAME2_LEN = 12;
    localparam int GET_INFO_LEN     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_RD_LAT,
        ST_READ,
        ST_GAP
    } bus_state_t;

endpackage

// File: rtl/stm32_bus_master_if.sv
// Host-side command, write-payload, read-payload and status signals of the bus master.
// The master modport belongs to whoever issues commands; the slave modport to the bus master core.
interface stm32_bus_master_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_code;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_code, cmd_dir, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_dir, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, cmd_err
    );
endinterface

// File: rtl/stm32_bus_wrbuf.sv
// Synchronous byte FIFO with occupancy count; head is the combinational oldest byte.
// Push is ignored when full and pop when empty; push+pop together keeps the count.
module stm32_bus_wrbuf #(
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [7:0]              push_dat,
    input  logic                    pop,
    output logic [7:0]              head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stm32_bus_master.sv
// Initiator of the DATA_BUS/DATA_SYNC command bus: one sync cycle with the code, then len payload bytes per clock.
// Writes stream from a pre-filled buffer (cmd_ready waits for enough bytes); reads have no back-pressure.
module stm32_bus_master
    import stm32_bus_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int WR_DEPTH = 32,
    parameter int GAP_CYC  = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    stm32_bus_master_if.slave host,
    inout  wire  [7:0]        DATA_BUS,
    output logic              DATA_SYNC
);
    localparam int CNT_W = $clog2(WR_DEPTH) + 1;
    localparam int CMP_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    bus_state_t        state;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  len_last;
    logic [LEN_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              dir_r;
    logic              oe;
    logic [7:0]        dout;
    logic [CNT_W-1:0]  buf_count;
    logic [7:0]        buf_head;
    logic              buf_full;
    logic              pop;
    logic              ready;
    logic              len_over;
    logic              len_fits;
    logic              accept;

    assign DATA_BUS = oe ? dout : 8'hzz;

    // Oversized writes are acknowledged so they can be rejected with cmd_err instead of stalling forever.
    assign len_over       = CMP_W'(host.cmd_len) > CMP_W'(WR_DEPTH);
    assign len_fits       = CMP_W'(buf_count) >= CMP_W'(host.cmd_len);
    assign ready          = (state == ST_IDLE) && (host.cmd_dir || len_fits || len_over);
    assign host.cmd_ready = ready;
    assign accept         = host.cmd_valid && ready;
    assign host.wr_ready  = !buf_full;
    assign len_last       = len_r - LEN_W'(1);

    // Pop on the edge that loads the byte into dout, so byte i is on the bus in WRITE cycle i.
    assign pop = ((state == ST_CMD) && !dir_r && (len_r != '0)) ||
                 ((state == ST_WRITE) && (cnt != len_last));

    stm32_bus_wrbuf #(
        .DEPTH (WR_DEPTH)
    ) u_wrbuf (
        .clk      (clk_in),
        .reset    (reset),
        .push     (host.wr_valid),
        .push_dat (host.wr_data),
        .pop      (pop),
        .head     (buf_head),
        .count    (buf_count),
        .full     (buf_full)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= ST_IDLE;
            DATA_SYNC     <= 1'b0;
            oe            <= 1'b0;
            dout          <= '0;
            len_r         <= '0;
            dir_r         <= 1'b0;
            cnt           <= '0;
            gap_cnt       <= '0;
            host.rd_data  <= '0;
            host.rd_valid <= 1'b0;
            host.done     <= 1'b0;
            host.cmd_err  <= 1'b0;
            host.busy     <= 1'b0;
        end else begin
            host.rd_valid <= 1'b0;
            host.done     <= 1'b0;
            host.cmd_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!host.cmd_dir && len_over) begin
                            host.cmd_err <= 1'b1;
                        end else begin
                            state     <= ST_CMD;
                            DATA_SYNC <= 1'b1;
                            oe        <= 1'b1;
                            dout      <= host.cmd_code;
                            len_r     <= host.cmd_len;
                            dir_r     <= host.cmd_dir;
                            host.busy <= 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    DATA_SYNC <= 1'b0;
                    cnt       <= '0;
                    if (len_r == '0) begin
                        state     <= ST_GAP;
                        oe        <= 1'b0;
                        gap_cnt   <= '0;
                        host.done <= 1'b1;
                    end else if (dir_r) begin
                        state <= ST_RD_LAT;
                        oe    <= 1'b0;
                    end else begin
                        state <= ST_WRITE;
                        dout  <= buf_head;
                    end
                end
                ST_WRITE: begin
                    if (cnt == len_last) begin
                        state     <= ST_GAP;
                        oe        <= 1'b0;
                        gap_cnt   <= '0;
                        host.done <= 1'b1;
                    end else begin
                        cnt  <= cnt + LEN_W'(1);
                        dout <= buf_head;
                    end
                end
                ST_RD_LAT: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    host.rd_data  <= DATA_BUS;
                    host.rd_valid <= 1'b1;
                    if (cnt == len_last) begin
                        state     <= ST_GAP;
                        gap_cnt   <= '0;
                        host.done <= 1'b1;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= ST_IDLE;
                        host.busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    DATA_SYNC <= 1'b0;
                    oe        <= 1'b0;
                    host.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stm32_bus_master.sv
// Bench for stm32_bus_master: directed commands against a behavioural responder, scoreboard monitor on the bus and host outputs.
module tb_stm32_bus_master;
    import stm32_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    wire  [7:0] data_bus;
    logic data_sync;

    stm32_bus_master_if #(.LEN_W(8)) bus_if ();

    stm32_bus_master #(.LEN_W(8), .WR_DEPTH(32), .GAP_CYC(2)) dut (
        .clk_in    (clk),
        .reset     (reset),
        .host      (bus_if.slave),
        .DATA_BUS  (data_bus),
        .DATA_SYNC (data_sync)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- responder model ----------------
    logic       resp_oe = 1'b0;
    logic [7:0] resp_dat = 8'h00;
    logic [7:0] resp_code = 8'h00;
    logic [3:0] ridx = 4'd0;
    logic       wmode = 1'b0;
    logic [6:0] widx = 7'd0;
    logic [7:0] rx_mem [64];

    assign data_bus = (resp_oe && !data_sync) ? resp_dat : 8'hzz;

    function automatic logic [7:0] resp_byte(input logic [7:0] code, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (code == GET_INFO) begin
            case (idx)
                4'd0:    b = 8'h04;
                4'd1:    b = 8'h00;
                default: b = 8'h01;
            endcase
        end else begin
            // rx2 frame: RX1 Q, RX1 I, RX2 Q, RX2 I, each 24-bit big-endian
            case (idx)
                4'd0:  b = 8'h12;
                4'd1:  b = 8'h34;
                4'd2:  b = 8'h56;
                4'd3:  b = 8'hAB;
                4'd4:  b = 8'hCD;
                4'd5:  b = 8'hEF;
                4'd6:  b = 8'h00;
                4'd7:  b = 8'h00;
                4'd8:  b = 8'h01;
                default: b = 8'hFF;
            endcase
        end
        return b;
    endfunction

    always @(posedge clk) begin
        if (data_sync) begin
            resp_code <= data_bus;
            ridx      <= 4'd0;
            widx      <= 7'd0;
            resp_oe   <= (data_bus == GET_INFO) || (data_bus == RX_IQ);
            wmode     <= !((data_bus == GET_INFO) || (data_bus == RX_IQ));
        end else begin
            if (resp_oe) begin
                resp_dat <= resp_byte(resp_code, ridx);
                ridx     <= (ridx == ((resp_code == GET_INFO) ? 4'd2 : 4'd11)) ? 4'd0 : ridx + 4'd1;
            end
            if (wmode && !widx[6]) begin
                rx_mem[widx[5:0]] <= data_bus;
                widx <= widx + 7'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       first;
        logic       last;
    } ent_t;

    typedef struct packed {
        logic [7:0] code;
        logic       zero;
    } sync_t;

    ent_t  exp_wr[$];
    ent_t  exp_rd[$];
    sync_t exp_sync[$];

    int n_tests = 0;
    int n_fail = 0;
    int done_seen = 0;
    int err_seen = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, expected none (t=%0t)", name, $time);
    endtask

    task automatic add_wr(input logic [7:0] d, input logic first, input logic last);
        exp_wr.push_back('{d: d, first: first, last: last});
    endtask

    task automatic add_rd(input logic [7:0] d, input logic first, input logic last);
        exp_rd.push_back('{d: d, first: first, last: last});
    endtask

    initial begin : monitor
        logic  pend_done;
        logic  wr_cont;
        logic  rd_cont;
        int    sync_cyc;
        ent_t  e;
        sync_t s;
        pend_done = 1'b0;
        wr_cont   = 1'b0;
        rd_cont   = 1'b0;
        sync_cyc  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_done = 1'b0;
                wr_cont   = 1'b0;
                rd_cont   = 1'b0;
                continue;
            end
            if (pend_done) begin
                check("done_after_last", bus_if.done, 1);
                check("oe_released", dut.oe, 0);
                pend_done = 1'b0;
            end
            if (data_sync) begin
                if (exp_sync.size() == 0) begin
                    unexpected("sync_unexpected");
                end else begin
                    s = exp_sync.pop_front();
                    check("sync_code", data_bus, s.code);
                    check("sync_oe", dut.oe, 1);
                    sync_cyc  = cyc;
                    pend_done = s.zero;
                end
            end else if (dut.oe) begin
                if (exp_wr.size() == 0) begin
                    unexpected("wr_unexpected");
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_byte", data_bus, e.d);
                    if (e.first) check("wr_latency", cyc - sync_cyc, 1);
                    pend_done = e.last;
                    wr_cont   = !e.last;
                end
            end else if (wr_cont) begin
                unexpected("wr_bubble");
                wr_cont = 1'b0;
            end
            if (bus_if.rd_valid) begin
                if (exp_rd.size() == 0) begin
                    unexpected("rd_unexpected");
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_byte", bus_if.rd_data, e.d);
                    check("rd_done", bus_if.done, e.last);
                    if (e.first) check("rd_latency", cyc - sync_cyc, 3);
                    rd_cont = !e.last;
                end
            end else if (rd_cont) begin
                unexpected("rd_bubble");
                rd_cont = 1'b0;
            end
            if (bus_if.done) done_seen++;
            if (bus_if.cmd_err) err_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] code, input logic dir, input logic [7:0] len);
        int n;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_code  = code;
        bus_if.cmd_dir   = dir;
        bus_if.cmd_len   = len;
        #1;
        n = 0;
        while (!bus_if.cmd_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("cmd_accept", bus_if.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = b;
        @(posedge clk);
        #1;
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.done && n < 500);
        check(name, bus_if.done, 1);
    endtask

    logic [7:0] gp [21];
    logic [7:0] rxq [12];

    initial begin
        int seen;
        int n;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_code  = 8'h00;
        bus_if.cmd_dir   = 1'b1;
        bus_if.cmd_len   = 8'h00;
        bus_if.wr_valid  = 1'b0;
        bus_if.wr_data   = 8'h00;
        gp[0] = 8'h07; gp[1] = 8'h00; gp[2] = 8'h03; gp[3] = 8'hB2; gp[4] = 8'hAB;
        for (int i = 5; i < 21; i++) gp[i] = 8'h10 + 8'(i);
        rxq = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sync", data_sync, 0);
        check("rst_oe", dut.oe, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_err", bus_if.cmd_err, 0);
        check("rst_rd_valid", bus_if.rd_valid, 0);
        check("rst_rd_data", bus_if.rd_data, 0);
        check("rst_wr_ready", bus_if.wr_ready, 1);

        // GET_PARAMS write, 21 bytes
        for (int i = 0; i < 21; i++) push(gp[i]);
        exp_sync.push_back('{code: GET_PARAMS, zero: 1'b0});
        for (int i = 0; i < 21; i++) add_wr(gp[i], i == 0, i == 20);
        issue(GET_PARAMS, 1'b0, 8'd21);
        wait_done("gp_done");
        check("gp_hdr", rx_mem[0], 8'h07);
        check("gp_nco1", {rx_mem[1], rx_mem[2], rx_mem[3], rx_mem[4]}, 32'h0003B2AB);
        check("gp_tail", rx_mem[20], 8'h24);

        // GET_INFO read, 3 bytes
        exp_sync.push_back('{code: GET_INFO, zero: 1'b0});
        add_rd(8'h04, 1'b1, 1'b0);
        add_rd(8'h00, 1'b0, 1'b0);
        add_rd(8'h01, 1'b0, 1'b1);
        issue(GET_INFO, 1'b1, 8'd3);
        wait_done("info_done");

        // RESET_ON, code only
        exp_sync.push_back('{code: RESET_ON, zero: 1'b1});
        issue(RESET_ON, 1'b0, 8'd0);
        wait_done("rston_done");
        check("rston_busy_gap0", bus_if.busy, 1);
        @(negedge clk);
        check("rston_busy_gap1", bus_if.busy, 1);
        @(negedge clk);
        check("rston_busy_idle", bus_if.busy, 0);

        // TX_IQ gated by buffer occupancy
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_code  = TX_IQ;
        bus_if.cmd_dir   = 1'b0;
        bus_if.cmd_len   = 8'd6;
        #1;
        check("txiq_ready_4a", bus_if.cmd_ready, 0);
        @(negedge clk);
        #1;
        check("txiq_ready_4b", bus_if.cmd_ready, 0);
        push(8'hA4);
        check("txiq_ready_5", bus_if.cmd_ready, 0);
        exp_sync.push_back('{code: TX_IQ, zero: 1'b0});
        for (int i = 0; i < 6; i++) add_wr(8'hA0 + 8'(i), i == 0, i == 5);
        push(8'hA5);
        check("txiq_ready_6", bus_if.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        wait_done("txiq_done");

        // oversized write is rejected
        issue(TX_IQ, 1'b0, 8'd40);
        @(negedge clk);
        check("rej_err_pulse", bus_if.cmd_err, 1);
        check("rej_busy", bus_if.busy, 0);
        @(negedge clk);
        check("rej_err_clear", bus_if.cmd_err, 0);

        // RX_IQ dual-receiver frame
        exp_sync.push_back('{code: RX_IQ, zero: 1'b0});
        for (int i = 0; i < 12; i++) add_rd(rxq[i], i == 0, i == 11);
        issue(RX_IQ, 1'b1, 8'd12);
        wait_done("rxiq_done");

        // reset during a 12-byte read, after byte 4 has been delivered
        exp_sync.push_back('{code: RX_IQ, zero: 1'b0});
        for (int i = 0; i < 5; i++) add_rd(rxq[i], i == 0, 1'b0);
        issue(RX_IQ, 1'b1, 8'd12);
        seen = 0;
        n = 0;
        while (seen < 5 && n < 500) begin
            @(negedge clk);
            if (bus_if.rd_valid) seen++;
            n++;
        end
        check("abort_reach", seen, 5);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_rd_valid", bus_if.rd_valid, 0);
        check("abort_done", bus_if.done, 0);
        check("abort_sync", data_sync, 0);
        check("abort_oe", dut.oe, 0);
        check("abort_busy", bus_if.busy, 0);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);

        check("end_sync_q", exp_sync.size(), 0);
        check("end_wr_q", exp_wr.size(), 0);
        check("end_rd_q", exp_rd.size(), 0);
        check("end_done_count", done_seen, 5);
        check("end_err_count", err_seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stm32_bus_master.md
Name: stm32_bus_master

Overview:
Initiator end of the 8-bit DATA_BUS / DATA_SYNC command bus, i.e. the STM32 side of the protocol. It is used as a second-board bus driver and as the bench driver for the FPGA-side responder.
- Per command: issues one DATA_SYNC cycle carrying the command code, then streams payload bytes out (write) or captures bytes in (read), one byte per clock.
- The responder cannot stall, so write payloads are pre-staged in an internal byte buffer.

Parameters:
LEN_W, 8, width of cmd_len.
WR_DEPTH, 32, write buffer depth in bytes (power of 2).
GAP_CYC, 2, idle cycles with DATA_SYNC low and bus released after every transaction.

Ports:
clk_in  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when both high.
cmd_code  in  8  command code driven during the sync cycle.
cmd_dir  in  1  0 = write payload to responder, 1 = read payload from responder.
cmd_len  in  LEN_W  payload bytes; 0 = code only.
wr_data  in  8  payload byte to buffer.
wr_valid  in  1  push strobe.
wr_ready  out  1  buffer not full.
rd_data  out  8  captured byte.
rd_valid  out  1  one-cycle strobe per byte; no back-pressure.
busy  out  1  transaction in progress.
done  out  1  one-cycle end-of-transaction pulse.
cmd_err  out  1  one-cycle pulse on rejected command.
DATA_BUS  inout  8  shared bus, tri-stated when not driving.
DATA_SYNC  out  1  command strobe.

Behaviour:
- Reset values: DATA_SYNC=0, bus OE=0, rd_valid=0, rd_data=0, done=0, cmd_err=0, busy=0, buffer empty, state IDLE.
- Reset mid-transaction aborts at once: the next cycle shows sync low and the bus released; no done, no further rd_valid.
- States: IDLE -> CMD -> (WRITE | RD_LAT -> READ) -> GAP -> IDLE.
- IDLE, cmd_ready rule: cmd_ready = (state==IDLE) && (cmd_dir==1 || buf_count >= cmd_len || cmd_len > WR_DEPTH).
- IDLE, rejection: a write with cmd_len > WR_DEPTH pulses cmd_err for one cycle, is not issued, and the state stays IDLE.
- CMD: exactly one cycle with DATA_SYNC=1, OE=1, bus=cmd_code. If cmd_len==0, go to GAP.
- WRITE: cycle i (i=0..len-1) drives the i-th buffered byte with OE=1 and DATA_SYNC=0. The buffer pops one byte per cycle. Bytes stay contiguous with no bubbles.
- Write timing: the responder samples byte i at the (i+1)-th edge after the CMD edge.
- RD_LAT: one cycle with OE=0, covering the responder's registered-output latency.
- READ: samples DATA_BUS on each of len edges. The k-th byte (k=0..len-1) is sampled at the (k+2)-th edge after the CMD edge. rd_data/rd_valid are registered, so they are visible in the following cycle.
- done timing:
  - Reads: done coincides with the last rd_valid.
  - Writes and len 0: done pulses in the first GAP cycle.
- GAP: GAP_CYC cycles with sync low and OE=0, then IDLE. busy stays high through GAP.
- Bus ownership: the master's OE is low in every state except CMD and WRITE. The responder releases the bus only on a sync edge, so the one-cycle overlap in the CMD cycle after a read is an intrinsic property of the protocol. The master adds no further contention.
- Buffer push/pop:
  - A push (wr_valid && wr_ready) is accepted in any state.
  - A simultaneous push and pop leaves the count unchanged.
  - A write consumes exactly cmd_len bytes; any extra bytes stay queued for the next command.
- Open-ended streams (e.g. RX IQ): use cmd_len = number of bytes wanted; the responder keeps looping until the next sync.
- Width rules: buf_count is log2(WR_DEPTH)+1 bits. The byte counter is LEN_W bits and compares with cmd_len-1; no wrap.

Decomposition:
- Package stm32_bus_pkg holds:
  - command codes: BUS_TEST=0, GET_PARAMS=1, SEND_PARAMS=2, TX_IQ=3, RX_IQ=4, RESET_ON=5, RESET_OFF=6, FLASH_READ=7, GET_INFO=8;
  - payload lengths: GET_PARAMS_LEN=21, SEND_PARAMS_LEN=11, TX_IQ_LEN=6, RX_IQ_FRAME_LEN=6/12, GET_INFO_LEN=3;
  - the state enum.
- One sub-module: stm32_bus_wrbuf, a synchronous byte FIFO with count output, push/pop and simultaneous-operation handling.

Test Plan:
1. GET_PARAMS write path.
   - Stimulus: push 21 bytes (0x07, 0x00,0x03,0xB2,0xAB, then 16 more), then cmd 0x01/write/len 21.
   - Required response: one sync cycle showing 0x01; 21 contiguous driven bytes in order; OE low after; done one cycle later; the responder model reads NCO1_freq=0x0003B2AB.
2. GET_INFO read path.
   - Stimulus: cmd 0x08/read/len 3 against the responder model.
   - Required response: rd_valid on 3 consecutive cycles with 0x04, 0x00, 0x01; the first strobe appears in the cycle after the 2nd edge following CMD; done with the last strobe.
3. RESET_ON, len 0.
   - Stimulus: cmd 0x05/write/len 0.
   - Required response: single sync cycle with 0x05; done in the next cycle; busy low after GAP_CYC cycles; buffer untouched.
4. Buffer gating and rejection.
   - Stimulus: 4 bytes buffered, cmd TX_IQ len 6; then push 2 more; separately issue a write with len 40.
   - Required response: cmd_ready stays low until the 6th push, then the transaction issues; the len-40 write pulses cmd_err and DATA_SYNC never rises.
5. RX IQ dual-receiver frame.
   - Stimulus: cmd 0x04/read/len 12 with the responder in rx2 mode, RX1 = Q 0x123456 / I 0xABCDEF, RX2 = Q 0x000001 / I 0xFFFFFF.
   - Required response: rd_data sequence 12 34 56 AB CD EF 00 00 01 FF FF FF.
6. Reset mid-READ.
   - Stimulus: assert reset at byte 5 of a 12-byte read.
   - Required response: no further rd_valid, no done, OE=0 and DATA_SYNC=0 in the next cycle, busy=0.
